// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parameterised synchronous FIFO.
// Optional error counters are enabled by defining FIFO_ERR_CNT_EN.
package fifo_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDepth = 8;
  localparam int unsigned DefAeTh  = 1;

  // Bit 0 is the accepted write, bit 1 the accepted read.
  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WR    = 2'b01,
    OP_RD    = 2'b10,
    OP_WR_RD = 2'b11
  } fifo_op_e;

  // Pointer width; count is one bit wider so it can hold DEPTH itself.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and acceptance logic for param_sync_fifo, plus the
// registered write-ack / overflow / underflow pulses.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned PtrW = ptr_width(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            wr_en_i,
  input  logic            rd_en_i,
  output logic            wr_accept_o,
  output logic            rd_accept_o,
  output logic [PtrW-1:0] wr_ptr_o,
  output logic [PtrW-1:0] rd_ptr_o,
  output logic [CntW-1:0] count_o,
  output logic            wr_ack_o,
  output logic            overflow_o,
  output logic            underflow_o
);

  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [PtrW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CntW-1:0] count_d, count_q;
  logic            wr_ack_d, wr_ack_q;
  logic            overflow_d, overflow_q;
  logic            underflow_d, underflow_q;
  logic            wr_accept, rd_accept;
  fifo_op_e        op;

  // A full FIFO still takes a write when a read frees the slot in the same cycle.
  always_comb begin
    rd_accept = rd_en_i && !flush_i && (count_q != '0);
    wr_accept = wr_en_i && !flush_i && ((count_q < DepthC) || rd_accept);
    op        = fifo_op_e'({rd_accept, wr_accept});
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wr_ack_d    = wr_accept;
    overflow_d  = wr_en_i && !flush_i && !wr_accept;
    underflow_d = rd_en_i && !flush_i && !rd_accept;
    unique case (op)
      OP_WR: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      OP_RD: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
      end
      OP_WR_RD: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      default: ;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_accept_o = wr_accept;
  assign rd_accept_o = rd_accept;
  assign wr_ptr_o    = wr_ptr_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign count_o     = count_q;
  assign wr_ack_o    = wr_ack_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with registered read data and status flags.
// Define FIFO_ERR_CNT_EN to add saturating overflow/underflow event counters.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AF_TH = DEPTH - 1,
  parameter int unsigned AE_TH = DefAeTh
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     rd_valid,
  output logic                     wr_ack,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     full,
  output logic                     empty,
  output logic                     almostfull,
  output logic                     almostempty,
`ifdef FIFO_ERR_CNT_EN
  output logic [15:0]              ovf_cnt,
  output logic [15:0]              udf_cnt,
`endif
  output logic [ptr_width(DEPTH):0] count
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfThC  = CntW'(AF_TH);
  localparam logic [CntW-1:0] AeThC  = CntW'(AE_TH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] data_out_d, data_out_q;
  logic             rd_valid_d, rd_valid_q;
  logic             wr_accept, rd_accept;
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [CntW-1:0]  count_w;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .wr_en_i     (wr_en),
    .rd_en_i     (rd_en),
    .wr_accept_o (wr_accept),
    .rd_accept_o (rd_accept),
    .wr_ptr_o    (wr_ptr),
    .rd_ptr_o    (rd_ptr),
    .count_o     (count_w),
    .wr_ack_o    (wr_ack),
    .overflow_o  (overflow),
    .underflow_o (underflow)
  );

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr] <= data_in;
    end
  end

  // When full with read+write, wr_ptr == rd_ptr; the read sees the old word.
  always_comb begin
    data_out_d = data_out_q;
    rd_valid_d = rd_accept;
    if (rd_accept) begin
      data_out_d = mem_q[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_w;

  always_comb begin
    full        = (count_w == DepthC);
    empty       = (count_w == '0);
    almostfull  = (count_w >= AfThC) && !full;
    almostempty = (count_w <= AeThC) && !empty;
  end

`ifdef FIFO_ERR_CNT_EN
  logic [15:0] ovf_cnt_d, ovf_cnt_q;
  logic [15:0] udf_cnt_d, udf_cnt_q;

  // Counts pulse events; not cleared by flush.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    udf_cnt_d = udf_cnt_q;
    if (overflow && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
    if (underflow && (udf_cnt_q != 16'hFFFF)) begin
      udf_cnt_d = udf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      udf_cnt_q <= udf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
  assign udf_cnt = udf_cnt_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo (WIDTH=16, DEPTH=8).
module tb_param_sync_fifo;

  logic        clk = 1'b0;
  logic        rst, flush, wr_en, rd_en;
  logic [15:0] data_in, data_out;
  logic        rd_valid, wr_ack, overflow, underflow;
  logic        full, empty, almostfull, almostempty;
  logic [3:0]  count;
`ifdef FIFO_ERR_CNT_EN
  logic [15:0] ovf_cnt, udf_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(
    .WIDTH (16),
    .DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty),
`ifdef FIFO_ERR_CNT_EN
    .ovf_cnt     (ovf_cnt),
    .udf_cnt     (udf_cnt),
`endif
    .count       (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic f, input logic [15:0] d);
    wr_en   = w;
    rd_en   = r;
    flush   = f;
    data_in = d;
  endtask

  // Inputs change 1ns after an edge; outputs are sampled 1ns after the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_word;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    step();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almostfull, 0);
    check("rst_ae", almostempty, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_data_out", data_out, 0);
    rst = 1'b0;

    // Fill
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'(16'h1000 + i));
      step();
      check("fill_wr_ack", wr_ack, 1);
      check("fill_count", count, i + 1);
      if (i == 0) check("fill_ae_at1", almostempty, 1);
      if (i == 6) check("fill_af_at7", almostfull, 1);
    end
    check("fill_full", full, 1);
    check("fill_af_full", almostfull, 0);
    drive(1'b1, 1'b0, 1'b0, 16'h9999);
    step();
    check("ovf_pulse", overflow, 1);
    check("ovf_wr_ack", wr_ack, 0);
    check("ovf_count", count, 8);

    // Full with simultaneous read and write
    drive(1'b1, 1'b1, 1'b0, 16'hBEEF);
    step();
    check("fs_wr_ack", wr_ack, 1);
    check("fs_overflow", overflow, 0);
    check("fs_rd_valid", rd_valid, 1);
    check("fs_data", data_out, 16'h1000);
    check("fs_count", count, 8);

    // Drain
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0);
      step();
      exp_word = (i == 7) ? 16'hBEEF : 16'(16'h1001 + i);
      check("drain_data", data_out, exp_word);
      check("drain_valid", rd_valid, 1);
    end
    check("drain_empty", empty, 1);

    // Empty with simultaneous read and write
    drive(1'b1, 1'b1, 1'b0, 16'h0055);
    step();
    check("es_underflow", underflow, 1);
    check("es_rd_valid", rd_valid, 0);
    check("es_count", count, 1);
    check("es_empty", empty, 0);
    check("es_ae", almostempty, 1);
    check("es_data_held", data_out, 16'hBEEF);
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    step();
    check("es_read", data_out, 16'h0055);
    check("es_count0", count, 0);

    // Wrap: 20 write/read pairs
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'(16'h2000 + i));
      step();
      drive(1'b0, 1'b1, 1'b0, 16'h0);
      step();
      check("wrap_data", data_out, 16'h2000 + i);
    end
    check("wrap_count", count, 0);

    // Flush at count 5 with a write pending
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'(16'h3000 + i));
      step();
    end
    check("pre_flush_count", count, 5);
    drive(1'b1, 1'b0, 1'b1, 16'h3333);
    step();
    check("flush_count", count, 0);
    check("flush_wr_ack", wr_ack, 0);
    check("flush_empty", empty, 1);
    check("flush_data_held", data_out, 16'h2013);
    drive(1'b1, 1'b0, 1'b0, 16'h4444);
    step();
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    step();
    check("post_flush_data", data_out, 16'h4444);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'(16'h5000 + i));
      step();
    end
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 16'h6666);
    step();
    check("mrst_count", count, 0);
    check("mrst_empty", empty, 1);
    check("mrst_data", data_out, 0);
    check("mrst_rd_valid", rd_valid, 0);
    check("mrst_wr_ack", wr_ack, 0);
    check("mrst_overflow", overflow, 0);
    check("mrst_underflow", underflow, 0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    step();

`ifdef FIFO_ERR_CNT_EN
    check("cnt_rst_ovf", ovf_cnt, 0);
    check("cnt_rst_udf", udf_cnt, 0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0);
      step();
    end
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 1'b0, 1'b0, 16'(16'h7000 + i));
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    step();
    check("cnt_ovf", ovf_cnt, 3);
    check("cnt_udf", udf_cnt, 2);
    drive(1'b0, 1'b0, 1'b1, 16'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    step();
    check("cnt_flush_ovf", ovf_cnt, 3);
    check("cnt_flush_udf", udf_cnt, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
